// File: rtl/dma_pkg.sv
// Shared definitions for the DMA-side streaming stages.
package dma_pkg;

   // Default output word width in bytes (legal: 2, 4, 8).
   localparam int unsigned DEF_OUT_BYTES = 4;

   // Width of the frame statistics counters.
   localparam int unsigned STAT_W = 16;

   // Packer accumulator state: empty, or holding a partial word.
   typedef enum logic {
      S_FILL = 1'b0,
      S_PART = 1'b1
   } pack_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output slice.
// - Holds one word and drives the m_* side.
// - Upstream may load whenever in_ready is high.
// - Loading while the held word drains replaces it with no bubble.
// - last_done is a registered pulse for an accepted tlast word.
module axis_out_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned KEEP_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic [KEEP_W-1:0] load_keep,
   input  logic              load_last,
   output logic              in_ready,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic [KEEP_W-1:0] m_tkeep,
   output logic              m_tlast,
   output logic              last_done
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [KEEP_W-1:0] keep_q;
   logic              last_q;
   logic              done_q;

   // Free slot when empty or when the held word leaves this cycle.
   assign in_ready = !valid_q || m_tready;

   // Output word register and downstream handshake.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= valid_q && m_tready && last_q;
         if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            keep_q  <= load_keep;
            last_q  <= load_last;
         end else if (m_tready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign m_tvalid  = valid_q;
   assign m_tdata   = data_q;
   assign m_tkeep   = keep_q;
   assign m_tlast   = last_q;
   assign last_done = done_q;

endmodule

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into OUT_BYTES-wide little-endian words with
// contiguous byte enables. tlast closes the current word, full or partial.
// Optional frame statistics (frame_cnt, last_len) under `PACKER_STATS_EN`;
// without it both outputs are tied to 0.
module axis_byte_packer
   import dma_pkg::*;
#(
   parameter int unsigned OUT_BYTES = DEF_OUT_BYTES
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   s_axis_tlast,
   input  logic [7:0]             s_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic [8*OUT_BYTES-1:0] m_axis_tdata,
   output logic [OUT_BYTES-1:0]   m_axis_tkeep,
   output logic                   frame_done,
   output logic [STAT_W-1:0]      frame_cnt,
   output logic [STAT_W-1:0]      last_len
);

   localparam int unsigned IDX_W  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
   localparam int unsigned DATA_W = 8 * OUT_BYTES;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);

   pack_state_e           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_W-1:0]     acc_data_q, acc_data_d;
   logic [OUT_BYTES-1:0]  acc_keep_q, acc_keep_d;
   logic [DATA_W-1:0]     word_data;
   logic [OUT_BYTES-1:0]  word_keep;
   logic                  accept;
   logic                  close;

   // Accumulator state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_FILL;
         idx_q      <= '0;
         acc_data_q <= '0;
         acc_keep_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_data_q <= acc_data_d;
         acc_keep_q <= acc_keep_d;
      end
   end

   // Merge the incoming byte into its lane and decide whether the word closes.
   always_comb begin
      // An empty accumulator contributes nothing, so unfilled lanes stay 0.
      word_data = (state_q == S_FILL) ? '0 : acc_data_q;
      word_keep = (state_q == S_FILL) ? '0 : acc_keep_q;
      word_data[{idx_q, 3'b000} +: 8] = s_axis_tdata;
      word_keep[idx_q] = 1'b1;

      accept = s_axis_tvalid && s_axis_tready;
      close  = accept && ((idx_q == LAST_IDX) || s_axis_tlast);

      state_d    = state_q;
      idx_d      = idx_q;
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;

      if (close) begin
         state_d    = S_FILL;
         idx_d      = '0;
         acc_data_d = '0;
         acc_keep_d = '0;
      end else if (accept) begin
         state_d    = S_PART;
         idx_d      = idx_q + 1'b1;
         acc_data_d = word_data;
         acc_keep_d = word_keep;
      end
   end

   axis_out_reg #(
      .DATA_W (DATA_W),
      .KEEP_W (OUT_BYTES)
   ) u_out_reg (
      .clk       (clk),
      .nrst      (nrst),
      .load      (close),
      .load_data (word_data),
      .load_keep (word_keep),
      .load_last (s_axis_tlast),
      .in_ready  (s_axis_tready),
      .m_tvalid  (m_axis_tvalid),
      .m_tready  (m_axis_tready),
      .m_tdata   (m_axis_tdata),
      .m_tkeep   (m_axis_tkeep),
      .m_tlast   (m_axis_tlast),
      .last_done (frame_done)
   );

`ifdef PACKER_STATS_EN
   logic [STAT_W-1:0] byte_cnt_q;
   logic [STAT_W-1:0] pend_len_q;
   logic [STAT_W-1:0] frame_cnt_q;
   logic [STAT_W-1:0] last_len_q;
   logic [STAT_W-1:0] byte_cnt_inc;
   logic              word_done;

   assign byte_cnt_inc = byte_cnt_q + 1'b1;
   assign word_done    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // Frame length is captured when the tlast word is loaded and published
   // only once that word is accepted downstream, alongside frame_done.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         byte_cnt_q  <= '0;
         pend_len_q  <= '0;
         frame_cnt_q <= '0;
         last_len_q  <= '0;
      end else begin
         if (accept) begin
            byte_cnt_q <= s_axis_tlast ? '0 : byte_cnt_inc;
         end
         if (close && s_axis_tlast) begin
            pend_len_q <= byte_cnt_inc;
         end
         if (word_done) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            last_len_q  <= pend_len_q;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign last_len  = last_len_q;
`else
   assign frame_cnt = '0;
   assign last_len  = '0;
`endif

endmodule
